// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream loader for the instruction store
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             cpu_rst_n,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] bytes_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_hi_q, len_hi_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cpu_rst_n_q, cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  logic             accept;
  logic [LEN_W-1:0] len_full;

  assign accept   = s_valid && s_ready_q;
  assign len_full = LEN_W'({len_hi_q, s_data});

  // Where the loader goes once the payload is exhausted (or empty)
  state_t end_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign end_state = S_CSUM;
`else
  assign end_state = S_DONE;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = s_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = len_full;
          count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
          if (len_full == '0) begin
            state_d = end_state;
          end else if (32'(len_full) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + 32'(count_q);
          mem_wdata_d = s_data;
          count_d     = count_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = sum_q + s_data;
`endif
          if (count_d == len_q) begin
            state_d = end_state;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (s_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          count_d = '0;
        end
      end
      default: state_d = S_LEN_HI;
    endcase

    // Status outputs are registered copies of the state being entered
    s_ready_d   = (state_d != S_DONE) && (state_d != S_ERR);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN_HI;
      len_hi_q    <= 8'h00;
      len_q       <= '0;
      count_q     <= '0;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign bytes_loaded = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        err;
  logic [15:0] bytes_loaded;

  int n_total  = 0;
  int n_passed = 0;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst_n    (cpu_rst_n),
    .done         (done),
    .err          (err),
    .bytes_loaded (bytes_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_write(input string tag, input logic [7:0] b, input logic [31:0] addr);
    push(b);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_data"}, mem_wdata, b);
  endtask

  task automatic close_load(input logic [7:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push(sum);
`else
    if (sum === 8'hxx) tick();
`endif
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13};
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 32'hBFC00000);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu", cpu_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bytes", bytes_loaded, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("ready_pre", s_ready, 0);
    tick();
    chk("ready_post", s_ready, 1);

    // 8-byte image, with an ignored start pulse mid-payload
    push(8'h00);
    push(8'h08);
    chk("hdr_no_we", mem_we, 0);
    for (int i = 0; i < 8; i++) begin
      push_write($sformatf("img%0d", i), prog[i], 32'hBFC00000 + 32'(i));
      if (i < 7) chk($sformatf("img%0d_notdone", i), done, 0);
      if (i == 2) begin
        pulse_start();
        chk("ign_start_we", mem_we, 0);
        chk("ign_start_cnt", bytes_loaded, 3);
      end
    end
    close_load(8'hC9);
    chk("img_done", done, 1);
    chk("img_cpu", cpu_rst_n, 1);
    chk("img_bytes", bytes_loaded, 8);
    chk("img_ready", s_ready, 0);
    tick();
    chk("img_we_off", mem_we, 0);

    // Oversized header
    pulse_start();
    chk("st_done", done, 0);
    chk("st_cpu", cpu_rst_n, 0);
    chk("st_ready", s_ready, 1);
    chk("st_bytes", bytes_loaded, 0);
    push(8'h10);
    push(8'h01);
    chk("big_we", mem_we, 0);
    chk("big_err", err, 1);
    chk("big_ready", s_ready, 0);
    chk("big_cpu", cpu_rst_n, 0);
    pulse_start();
    chk("big_clr", err, 0);
    chk("big_ready2", s_ready, 1);

    // Empty image
    push(8'h00);
    push(8'h00);
    chk("zero_we", mem_we, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("zero_wait", done, 0);
    push(8'h00);
`endif
    chk("zero_done", done, 1);
    chk("zero_cpu", cpu_rst_n, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    push(8'h00);
    push(8'h00);
    push(8'h01);
    chk("zero_bad_err", err, 1);
`endif

    // Gapped s_valid over a 3-byte payload
    pulse_start();
    push(8'h00);
    push(8'h03);
    push_write("gap0", 8'hAA, 32'hBFC00000);
    tick();
    chk("gap0_idle", mem_we, 0);
    push_write("gap1", 8'hBB, 32'hBFC00001);
    tick();
    chk("gap1_idle", mem_we, 0);
    chk("gap1_bytes", bytes_loaded, 2);
    push_write("gap2", 8'hCC, 32'hBFC00002);
    close_load(8'h31);
    chk("gap_done", done, 1);
    chk("gap_bytes", bytes_loaded, 3);

    // Asynchronous reset mid-load, then a fresh load
    pulse_start();
    push(8'h00);
    push(8'h06);
    push_write("mid0", 8'h01, 32'hBFC00000);
    push_write("mid1", 8'h02, 32'hBFC00001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ready", s_ready, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_addr, 32'hBFC00000);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_bytes", bytes_loaded, 0);
    chk("mid_cpu", cpu_rst_n, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_ready2", s_ready, 1);
    push(8'h00);
    push(8'h02);
    push_write("fresh0", 8'h11, 32'hBFC00000);
    push_write("fresh1", 8'h22, 32'hBFC00001);
    close_load(8'h33);
    chk("fresh_done", done, 1);
    chk("fresh_bytes", bytes_loaded, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    push(8'h00);
    push(8'h03);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h07);
    chk("csum_bad_err", err, 1);
    chk("csum_bad_cpu", cpu_rst_n, 0);
`endif

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
